// File: rtl/mul_share_ctrl.sv
// Round-robin front end that time-shares one load/reset-controlled multiplier
// between two valid/ready requesters and returns each product on a shared bus.
module mul_share_ctrl #(
  parameter int WIDTH       = 6,
  parameter int MUL_LATENCY = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req0_valid,
  input  logic [WIDTH-1:0]     req0_a,
  input  logic [WIDTH-1:0]     req0_b,
  output logic                 req0_ready,
  input  logic                 req1_valid,
  input  logic [WIDTH-1:0]     req1_a,
  input  logic [WIDTH-1:0]     req1_b,
  output logic                 req1_ready,
  output logic                 rsp0_valid,
  input  logic                 rsp0_ready,
  output logic                 rsp1_valid,
  input  logic                 rsp1_ready,
  output logic [2*WIDTH-1:0]   rsp_product,
  output logic                 mul_reset,
  output logic                 mul_load,
  output logic [WIDTH-1:0]     mul_a,
  output logic [WIDTH-1:0]     mul_b,
  input  logic [2*WIDTH-1:0]   mul_product,
  output logic                 busy
);

  localparam int CNT_W = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_LATENCY - 1);

  typedef enum logic [1:0] {IDLE, LOAD, WAIT, DONE} state_t;

  state_t           state;
  logic             last_grant;
  logic             grant;
  logic [CNT_W-1:0] cnt;
  logic             idle;
  logic             sel;
  logic             accept;
  logic             rsp_fire;

  // Requester 1 wins when it is alone, or when both ask and 0 was served last.
  assign idle       = (state == IDLE);
  assign sel        = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
  assign req0_ready = idle && req0_valid && !sel;
  assign req1_ready = idle && req1_valid && sel;
  assign accept     = req0_ready || req1_ready;
  assign rsp_fire   = grant ? (rsp1_valid && rsp1_ready) : (rsp0_valid && rsp0_ready);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      last_grant  <= 1'b1;
      grant       <= 1'b0;
      cnt         <= '0;
      mul_a       <= '0;
      mul_b       <= '0;
      rsp_product <= '0;
      mul_reset   <= 1'b1;
      mul_load    <= 1'b0;
      busy        <= 1'b0;
      rsp0_valid  <= 1'b0;
      rsp1_valid  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            mul_a     <= sel ? req1_a : req0_a;
            mul_b     <= sel ? req1_b : req0_b;
            grant     <= sel;
            state     <= LOAD;
            mul_reset <= 1'b0;
            mul_load  <= 1'b1;
            busy      <= 1'b1;
          end
        end
        LOAD: begin
          cnt      <= CNT_LOAD;
          mul_load <= 1'b0;
          state    <= WAIT;
        end
        WAIT: begin
          if (cnt == '0) begin
            rsp_product <= mul_product;
            rsp0_valid  <= ~grant;
            rsp1_valid  <= grant;
            state       <= DONE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        DONE: begin
          // Arbitration pointer only advances once the product has been taken.
          if (rsp_fire) begin
            last_grant <= grant;
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            mul_reset  <= 1'b1;
            busy       <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mul_share_ctrl.md
# mul_share_ctrl

Controller that shares one shift-and-add multiplier (6x6 -> 12-bit, load/reset-controlled) between two requesters. It arbitrates round-robin, captures operands with a valid/ready handshake, and sequences the multiplier's reset and load. It waits a fixed latency, then returns the product to the granted requester with a valid/ready response. It sits between two datapath clients and the single multiplier instance.

## Interface
- WIDTH, 6, operand width; product is 2*WIDTH
- MUL_LATENCY, 6, clock edges from the multiplier's load-capture edge to a valid mul_product (legal range >= 1)

- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- req0_valid / req1_valid  in  1  requester has operands
- req0_a, req0_b / req1_a, req1_b  in  WIDTH  unsigned operands
- req0_ready / req1_ready  out  1  controller accepts operands this cycle (combinational)
- rsp0_valid / rsp1_valid  out  1  product available for that requester
- rsp0_ready / rsp1_ready  in  1  requester takes product
- rsp_product  out  2*WIDTH  shared result bus
- mul_reset  out  1  drives multiplier reset
- mul_load  out  1  drives multiplier load
- mul_a, mul_b  out  WIDTH  multiplier operands
- mul_product  in  2*WIDTH  multiplier result
- busy  out  1  high whenever state != IDLE

## Operation
- FSM states: IDLE, LOAD, WAIT, DONE.
- IDLE:
  - mul_reset=1, mul_load=0.
  - Selects one requester: if only one is valid, that one; if both are valid, the one not served last.
  - last_grant pointer after reset favours requester 0.
  - Asserts ready only to the selected requester; never both.
  - On valid&&ready at an edge: latch a, b and the grant id into operand/grant registers; go to LOAD.
- LOAD (exactly 1 cycle):
  - mul_reset=0, mul_load=1, mul_a/mul_b from operand registers.
  - At the closing edge: cnt <= MUL_LATENCY-1; go to WAIT.
- WAIT:
  - mul_reset=0, mul_load=0, operands held.
  - At each edge: if cnt==0, rsp_product <= mul_product and go to DONE; else cnt decrements.
- DONE:
  - rspN_valid=1 for the granted requester only.
  - rsp_product is held stable.
  - On rspN_valid&&rspN_ready: last_grant <= grant id; go to IDLE.
- Outside DONE, both rsp valids are 0.
- Outside IDLE, both req readys are 0. Requests wait; requesters must hold valid and operands stable.
- mul_a/mul_b hold the operand registers in all states. Operand registers change only on acceptance.
- Arithmetic: unsigned; rsp_product equals the full 2*WIDTH-bit mul_product with no truncation.
- Boundary rules:
  - A requester that drops valid before ready: no transfer, no state change.
  - rspN_ready high before rspN_valid: no effect.
  - Both requesters valid in the same cycle as a response completes: no accept in that cycle. Arbitration happens in the following IDLE cycle using the updated last_grant.
  - Zero operands give product 0 through the normal sequence.
- Reset (any state, including mid-WAIT or DONE):
  - Next state is IDLE; last_grant selects requester 0; cnt=0.
  - Operand registers and rsp_product cleared to 0.
  - Any pending response is discarded.

## Timing
- Reset values: req0_ready/req1_ready per IDLE rule (0 if no valid), rsp0_valid=0, rsp1_valid=0, rsp_product=0, mul_reset=1, mul_load=0, mul_a=0, mul_b=0, busy=0.
- Accept edge E0.
  - LOAD occupies the cycle after E0; the multiplier captures at E1.
  - The product is captured at E1+MUL_LATENCY; rspN_valid is high from that edge.
  - This is MUL_LATENCY+1 edges after acceptance (7 for the default).
- Minimum turnaround per job: MUL_LATENCY+3 cycles (IDLE accept, LOAD, WAIT, DONE with immediate ready).
- mul_load is high for exactly one cycle per job.

## Test plan
- Single job: req0 a=5, b=6 valid after reset -> req0_ready at the first edge; mul_load high for 1 cycle with mul_a=5, mul_b=6; rsp0_valid 7 edges after acceptance; rsp_product=30; rsp1_valid stays 0.
- Contention: both requesters continuously valid (req0 3x4, req1 7x9) -> grants alternate 0,1,0,1 starting with 0; products 12, 63, 12, 63; ready is never high to both.
- Backpressure: req1 job 63x63, rsp1_ready low for 3 cycles after rsp1_valid -> rsp1_valid and rsp_product=3969 held stable; busy=1; req0_ready stays 0 until rsp1 handshake, then req0 is accepted the next cycle.
- Reset mid-WAIT: assert reset for 1 cycle during WAIT -> next cycle all outputs at reset values, no rsp_valid. A following req1 job 2x3 yields rsp1 product 6; priority after reset is 0 if both are valid.
- Parameter corner: MUL_LATENCY=1, req0 10x10 -> rsp0_valid 2 edges after acceptance, product 100.
- Withdrawn request: req1_valid pulsed low before acceptance while req0 busy -> no job issued for req1; mul_load count equals accepted handshakes.
